eth_unpacker: RTL and testbench



---
 rtl/eth_pkg.sv | 40 ++++
 rtl/eth_unpacker_if.sv | 22 ++
 rtl/eth_crc32_dibit.sv | 26 ++
 rtl/eth_unpacker.sv | 205 ++++++++++++++++++++
 tb/tb_eth_unpacker.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the RMII pixel-link deframer and its CRC engine.
// Holds the receive FSM state type, CRC-32 constants and the dibit-step helper.
// The helper is used both by the CRC register and by the top-level FCS look-ahead.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_PREAMBLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_FCS
    } state_e;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT      = 2'b11;

    // One reflected CRC-32 step over a dibit; dibit[0] is the earlier wire bit.
    function automatic logic [31:0] crc32_dibit_step(input logic [31:0] crc,
                                                     input logic [1:0]  dibit);
        logic [31:0] r;
        r = crc;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ dibit[i]) r = (r >> 1) ^ CRC_POLY_REFL;
            else                 r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

endpackage

// File: rtl/eth_unpacker_if.sv
// RMII receive pins plus the pixel write / packet status stream of the deframer.
// master: deframer side (samples crsdv/rxd, drives pixel and status outputs).
// slave : environment side (drives the PHY pins, observes the outputs).
interface eth_unpacker_if;
    logic        crsdv;       // PHY carrier-sense / data-valid
    logic [1:0]  rxd;         // PHY receive dibit, rxd[0] lower bit
    logic        axiov;       // one-cycle strobe, axiod/pixel_addr valid
    logic [7:0]  axiod;       // reassembled pixel byte
    logic [23:0] pixel_addr;  // frame address of axiod
    logic        pkt_done;    // packet received with good FCS
    logic        pkt_err;     // packet bad (FCS mismatch or truncated)

    modport master (
        input  crsdv, rxd,
        output axiov, axiod, pixel_addr, pkt_done, pkt_err
    );

    modport slave (
        output crsdv, rxd,
        input  axiov, axiod, pixel_addr, pkt_done, pkt_err
    );
endinterface

// File: rtl/eth_crc32_dibit.sv
// Purpose: reflected CRC-32 register updated two bits per clock (RMII rate).
// Latency: crc reflects a dibit one cycle after en; clr wins over en.
// Backpressure: none, consumes a dibit every cycle en is high.
// Ports: clk/rst_n, clr (reload CRC_INIT), en (absorb dibit), dibit, crc (register).
module eth_crc32_dibit
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [1:0]  dibit,
    output logic [31:0] crc
);

    logic [31:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   r_crc <= CRC_INIT;
        else if (clr) r_crc <= CRC_INIT;
        else if (en)  r_crc <= crc32_dibit_step(r_crc, dibit);
    end

    assign crc = r_crc;

endmodule

// File: rtl/eth_unpacker.sv
// Purpose: RMII deframer - preamble/SFD lock, header skip, pixel byte rebuild, FCS check.
// Latency: axiov 1 cycle after a byte's 4th dibit; pkt_done/pkt_err 1 cycle after last FCS dibit or crsdv drop.
// Backpressure: none, the wire rate is fixed and strobes come every 4 cycles.
// Ports: clk, rst_n (async active-low), bus (master modport: crsdv/rxd in; axiov/axiod/pixel_addr/pkt_done/pkt_err out).
module eth_unpacker
    import eth_pkg::*;
#(
    parameter int HEADER_BYTES  = 14,
    parameter int PAYLOAD_BYTES = 320,
    parameter int FCS_BYTES     = 4,
    parameter int PREAMBLE_MIN  = 8,
    parameter int FRAME_PIXELS  = 76800
) (
    input  logic          clk,
    input  logic          rst_n,
    eth_unpacker_if.master bus
);

    localparam int HDR_DIBITS = HEADER_BYTES * 4;
    localparam int PAY_DIBITS = PAYLOAD_BYTES * 4;
    localparam int FCS_DIBITS = FCS_BYTES * 4;
    localparam int MAX_DIBITS = (HDR_DIBITS > PAY_DIBITS)
                              ? ((HDR_DIBITS > FCS_DIBITS) ? HDR_DIBITS : FCS_DIBITS)
                              : ((PAY_DIBITS > FCS_DIBITS) ? PAY_DIBITS : FCS_DIBITS);
    localparam int CNT_W = $clog2(MAX_DIBITS + 1);
    localparam int PRE_W = $clog2(PREAMBLE_MIN + 1);

    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_DIBITS - 1);
    localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAY_DIBITS - 1);
    localparam logic [CNT_W-1:0] FCS_LAST  = CNT_W'(FCS_DIBITS - 1);
    localparam logic [23:0]      ADDR_LAST = 24'(FRAME_PIXELS - 1);

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [PRE_W-1:0]   r_pre_cnt, w_pre_cnt_nxt;
    logic [5:0]         r_shift;
    logic               r_axiov;
    logic [7:0]         r_axiod;
    logic [23:0]        r_pixel_addr;
    logic [23:0]        r_pkt_base;
    logic               r_pkt_done;
    logic               r_pkt_err;

    logic               w_crsdv;
    logic [1:0]         w_rxd;
    logic               w_emit;
    logic               w_done;
    logic               w_err;
    logic               w_crc_clr;
    logic               w_crc_en;
    logic               w_save_base;
    logic               w_fcs_ok;
    logic [31:0]        w_crc;
    logic [23:0]        w_addr_inc;

    assign w_crsdv = bus.crsdv;
    assign w_rxd   = bus.rxd;

    eth_crc32_dibit u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_crc_clr),
        .en    (w_crc_en),
        .dibit (w_rxd),
        .crc   (w_crc)
    );

    // The verdict is taken on the cycle of the last FCS dibit, so look one
    // step ahead. The register is reflected (LSB = x^31) while the residue
    // constant is written in normal bit order, hence the reversal.
    assign w_fcs_ok = (bitrev32(crc32_dibit_step(w_crc, w_rxd)) == CRC_RESIDUE);

    assign w_addr_inc = (r_pixel_addr == ADDR_LAST) ? 24'd0 : r_pixel_addr + 24'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_WAIT_IDLE;
            r_cnt     <= '0;
            r_pre_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pre_cnt <= w_pre_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pre_cnt_nxt = r_pre_cnt;
        w_emit        = 1'b0;
        w_done        = 1'b0;
        w_err         = 1'b0;
        w_crc_clr     = 1'b0;
        w_crc_en      = 1'b0;
        w_save_base   = 1'b0;

        unique case (r_state)
            // Also the landing state after a packet, so trailing dibits of an
            // over-long frame are dropped until carrier goes away.
            ST_WAIT_IDLE: begin
                if (!w_crsdv) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_crsdv && w_rxd == PREAMBLE_DIBIT) begin
                    w_state_nxt   = ST_PREAMBLE;
                    w_pre_cnt_nxt = PRE_W'(1);
                end
            end
            ST_PREAMBLE: begin
                if (!w_crsdv) begin
                    w_state_nxt = ST_WAIT_IDLE;
                end else if (w_rxd == PREAMBLE_DIBIT) begin
                    if (r_pre_cnt != '1) w_pre_cnt_nxt = r_pre_cnt + PRE_W'(1);
                end else if (w_rxd == SFD_DIBIT && r_pre_cnt >= PRE_W'(PREAMBLE_MIN)) begin
                    w_state_nxt = ST_HEADER;
                    w_cnt_nxt   = '0;
                    w_crc_clr   = 1'b1;
                    w_save_base = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT_IDLE;
                end
            end
            ST_HEADER: begin
                if (!w_crsdv) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_crc_en = 1'b1;
                    if (r_cnt == HDR_LAST) begin
                        w_state_nxt = ST_PAYLOAD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!w_crsdv) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_crc_en = 1'b1;
                    // Payload starts byte-aligned, so the low counter bits
                    // give the dibit position inside the current byte.
                    w_emit   = (r_cnt[1:0] == 2'd3);
                    if (r_cnt == PAY_LAST) begin
                        w_state_nxt = ST_FCS;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_FCS: begin
                if (!w_crsdv) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_crc_en = 1'b1;
                    if (r_cnt == FCS_LAST) begin
                        w_done      = w_fcs_ok;
                        w_err       = !w_fcs_ok;
                        w_state_nxt = ST_WAIT_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_axiov      <= 1'b0;
            r_axiod      <= '0;
            r_pixel_addr <= '0;
            r_pkt_base   <= '0;
            r_pkt_done   <= 1'b0;
            r_pkt_err    <= 1'b0;
        end else begin
            // Newest dibit enters at the top: after three shifts the
            // register holds {d2,d1,d0} ready for d3 to complete the byte.
            if (w_crsdv) r_shift <= {w_rxd, r_shift[5:2]};
            r_axiov <= w_emit;
            if (w_emit) r_axiod <= {w_rxd, r_shift};
            r_pkt_done <= w_done;
            r_pkt_err  <= w_err;
            if (w_save_base) r_pkt_base <= r_pixel_addr;
            // A rejected packet rolls the address back so the frame buffer
            // region gets rewritten by the retransmission.
            if (w_err)        r_pixel_addr <= r_pkt_base;
            else if (r_axiov) r_pixel_addr <= w_addr_inc;
        end
    end

    assign bus.axiov      = r_axiov;
    assign bus.axiod      = r_axiod;
    assign bus.pixel_addr = r_pixel_addr;
    assign bus.pkt_done   = r_pkt_done;
    assign bus.pkt_err    = r_pkt_err;

endmodule

// File: tb/tb_eth_unpacker.sv
// Purpose: scoreboard bench for the RMII deframer with a reduced frame size.
// Latency: expects axiov 1 cycle after each byte and status 1 cycle after the packet end.
// Backpressure: none; stimulus runs at one dibit per clock.
module tb_eth_unpacker;

    localparam int HDR   = 14;
    localparam int PAY   = 320;
    localparam int FRAME = 640;
    localparam logic [31:0] POLY = 32'hEDB8_8320;

    typedef struct packed {
        logic [23:0] addr;
        logic [7:0]  dat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    eth_unpacker_if u_if ();

    eth_unpacker #(
        .HEADER_BYTES  (HDR),
        .PAYLOAD_BYTES (PAY),
        .FCS_BYTES     (4),
        .PREAMBLE_MIN  (8),
        .FRAME_PIXELS  (FRAME)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    exp_t q_dat[$];
    int   q_evt[$];       // 1 = pkt_done, 2 = pkt_err
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_addr   = 0;
    int   m_base   = 0;
    exp_t m_e;
    int   m_ev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic send_dibit(input logic v, input logic [1:0] d);
        @(posedge clk);
        #1;
        u_if.crsdv = v;
        u_if.rxd   = d;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) send_dibit(1'b1, b[2*i +: 2]);
    endtask

    task automatic crc_byte(inout logic [31:0] crc, input logic [7:0] b);
        crc = crc ^ {24'd0, b};
        for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ POLY) : (crc >> 1);
    endtask

    function automatic int next_addr(input int a);
        return (a == FRAME - 1) ? 0 : a + 1;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_axiov"}, 32'(u_if.axiov), 32'd0);
        check({tag, "_axiod"}, 32'(u_if.axiod), 32'd0);
        check({tag, "_addr"},  32'(u_if.pixel_addr), 32'd0);
        check({tag, "_done"},  32'(u_if.pkt_done), 32'd0);
        check({tag, "_err"},   32'(u_if.pkt_err), 32'd0);
    endtask

    task automatic idle_and_settle(input string tag);
        repeat (12) send_dibit(1'b0, 2'b00);
        check({tag, "_dat_left"}, 32'(q_dat.size()), 32'd0);
        check({tag, "_evt_left"}, 32'(q_evt.size()), 32'd0);
        check({tag, "_addr_end"}, 32'(u_if.pixel_addr), 32'(m_addr));
    endtask

    // accept=0 models a frame the deframer must ignore (short preamble).
    task automatic send_packet(input string tag, input int pre_len, input bit rand_pay,
                               input int trunc_at, input bit bad_fcs, input bit accept);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  b;
        bit          trunc;
        int          ev;
        crc   = 32'hFFFF_FFFF;
        trunc = 1'b0;
        for (int i = 0; i < pre_len; i++) send_dibit(1'b1, 2'b01);
        send_dibit(1'b1, 2'b11);
        if (accept) m_base = m_addr;
        for (int i = 0; i < HDR; i++) begin
            b = 8'($urandom);
            crc_byte(crc, b);
            send_byte(b);
        end
        for (int i = 0; i < PAY; i++) begin
            if (i == trunc_at) begin
                send_dibit(1'b0, 2'b00);
                trunc = 1'b1;
                break;
            end
            b = rand_pay ? 8'($urandom) : 8'hFF;
            crc_byte(crc, b);
            if (accept) begin
                q_dat.push_back('{addr: 24'(m_addr), dat: b});
                m_addr = next_addr(m_addr);
            end
            send_byte(b);
        end
        if (!trunc) begin
            fcs = ~crc;
            for (int k = 0; k < 4; k++) begin
                b = fcs[8*k +: 8];
                if (bad_fcs && k == 3) b = ~b;
                send_byte(b);
            end
        end
        ev = 0;
        if (accept) begin
            ev = (trunc || bad_fcs) ? 2 : 1;
            q_evt.push_back(ev);
            if (ev == 2) m_addr = m_base;
        end
        // Status must be visible exactly one cycle after the final dibit.
        @(posedge clk);
        @(negedge clk);
        check({tag, "_status_lat"}, 32'({u_if.pkt_done, u_if.pkt_err}),
              (ev == 1) ? 32'd2 : (ev == 2) ? 32'd1 : 32'd0);
        idle_and_settle(tag);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.axiov) begin
                if (q_dat.size() == 0) begin
                    check("axiov_extra", 32'(u_if.axiov), 32'd0);
                end else begin
                    m_e = q_dat.pop_front();
                    check("axiod", 32'(u_if.axiod), 32'(m_e.dat));
                    check("pixel_addr", 32'(u_if.pixel_addr), 32'(m_e.addr));
                end
            end
            if (u_if.pkt_done || u_if.pkt_err) begin
                check("flag_excl", 32'({u_if.axiov, u_if.pkt_done & u_if.pkt_err}), 32'd0);
                if (q_evt.size() == 0) begin
                    check("status_extra", 32'({u_if.pkt_done, u_if.pkt_err}), 32'd0);
                end else begin
                    m_ev = q_evt.pop_front();
                    check("status", 32'({u_if.pkt_done, u_if.pkt_err}), (m_ev == 1) ? 32'd2 : 32'd1);
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        u_if.crsdv = 1'b0;
        u_if.rxd   = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (5) send_dibit(1'b0, 2'b00);

        send_packet("good_ff",   8, 1'b0, -1,  1'b0, 1'b1);  // 0..319, done
        send_packet("bad_fcs",   8, 1'b1, -1,  1'b1, 1'b1);  // 320..639, err, back to 320
        send_packet("b2b_wrap",  8, 1'b1, -1,  1'b0, 1'b1);  // 320..639, done, wraps to 0
        send_packet("trunc",     8, 1'b1, 100, 1'b0, 1'b1);  // 0..99, err, back to 0
        send_packet("short_pre", 3, 1'b1, -1,  1'b0, 1'b0);  // ignored
        send_packet("good_2",    8, 1'b0, -1,  1'b0, 1'b1);  // 0..319, done

        // Reset in the middle of a payload: outputs clear at once and the
        // rest of the frame, including a fake preamble/SFD, is ignored.
        for (int i = 0; i < 8; i++) send_dibit(1'b1, 2'b01);
        send_dibit(1'b1, 2'b11);
        for (int i = 0; i < HDR; i++) send_byte(8'($urandom));
        for (int i = 0; i < 50; i++) begin
            b = 8'($urandom);
            q_dat.push_back('{addr: 24'(m_addr), dat: b});
            m_addr = next_addr(m_addr);
            send_byte(b);
        end
        send_dibit(1'b1, 2'b10);
        send_dibit(1'b1, 2'b01);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        m_addr = 0;
        send_dibit(1'b1, 2'b10);
        send_dibit(1'b1, 2'b11);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) send_dibit(1'b1, 2'b01);
        send_dibit(1'b1, 2'b11);
        for (int i = 0; i < 200; i++) send_byte(8'($urandom));
        idle_and_settle("midreset");

        send_packet("after_rst", 8, 1'b1, -1, 1'b0, 1'b1);   // 0..319, done

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
